// File: rtl/intr_pkg.sv
// Shared types and constants for the priority interrupt controller.
package intr_pkg;

  localparam int unsigned NUM_SRC_DEF = 8;
  localparam int unsigned VEC_W_DEF   = 8;
  localparam int unsigned CFG_W       = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_MODE = 2'd1;
  localparam logic [1:0] ADDR_BASE = 2'd2;
  localparam logic [1:0] ADDR_CLR  = 2'd3;

  // Every source comes out of reset masked.
  localparam logic [CFG_W-1:0] RST_MASK = 8'hFF;

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Lowest-index-first priority encoder; combinational, outputs carry the _c suffix.
module prio_enc #(
  parameter int unsigned N    = 8,
  parameter int unsigned ID_W = 3
) (
  input  logic [N-1:0]    i_req,
  output logic            o_valid_c,
  output logic [ID_W-1:0] o_id_c
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_valid_c = 1'b0;
    o_id_c    = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid_c = 1'b1;
        o_id_c    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Priority interrupt controller: pending/mask/mode/ISR tracking, one intr/inta
// handshake to the CPU with a registered vector, and EOI-driven ISR retirement.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned VEC_W   = VEC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  output logic               intr,
  input  logic               inta,
  output logic [VEC_W-1:0]   vector,
  input  logic               eoi,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [CFG_W-1:0]   cfg_wdata,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [NUM_SRC-1:0] isr_o
);

  localparam int unsigned ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t             r_state;
  logic               r_intr;
  logic [VEC_W-1:0]   r_vector;
  logic [ID_W-1:0]    r_vec_id;
  logic [NUM_SRC-1:0] r_irq_q;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_isr;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_mode;
  logic [VEC_W-1:0]   r_base;

  logic [NUM_SRC-1:0] w_cand_req;
  logic               w_cand_valid;
  logic [ID_W-1:0]    w_cand_id;
  logic               w_isr_valid;
  logic [ID_W-1:0]    w_isr_id;
  logic               w_cand_ok;
  logic [VEC_W-1:0]   w_cand_vec;
  logic               w_grant;
  logic [NUM_SRC-1:0] w_grant_oh;
  logic [NUM_SRC-1:0] w_eoi_oh;
  logic [NUM_SRC-1:0] w_cfg_clr;
  logic [NUM_SRC-1:0] w_edge_next;
  logic [NUM_SRC-1:0] w_pending_next;
  logic [NUM_SRC-1:0] w_isr_next;

  assign w_cand_req = r_pending & ~r_mask & ~r_isr;

  prio_enc #(.N(NUM_SRC), .ID_W(ID_W)) u_cand_enc (
    .i_req     (w_cand_req),
    .o_valid_c (w_cand_valid),
    .o_id_c    (w_cand_id)
  );

  prio_enc #(.N(NUM_SRC), .ID_W(ID_W)) u_isr_enc (
    .i_req     (r_isr),
    .o_valid_c (w_isr_valid),
    .o_id_c    (w_isr_id)
  );

  // A candidate must outrank every interrupt already in service.
  assign w_cand_ok  = w_cand_valid && (!w_isr_valid || (w_cand_id < w_isr_id));
  assign w_cand_vec = VEC_W'(r_base + VEC_W'(w_cand_id));

  // The grant always targets the id currently presented on vector.
  assign w_grant    = (r_state == ST_REQ) && inta;
  assign w_grant_oh = w_grant ? (NUM_SRC'(1) << r_vec_id) : '0;
  assign w_eoi_oh   = (eoi && w_isr_valid) ? (NUM_SRC'(1) << w_isr_id) : '0;
  assign w_cfg_clr  = (cfg_we && (cfg_addr == ADDR_CLR)) ? NUM_SRC'(cfg_wdata) : '0;

  // Edge sources: set wins over grant/cfg clear; level sources track irq.
  assign w_edge_next    = (r_pending & ~(w_grant_oh | w_cfg_clr)) | (irq & ~r_irq_q);
  assign w_pending_next = (r_mode & w_edge_next) | (~r_mode & irq);
  assign w_isr_next     = (r_isr & ~w_eoi_oh) | w_grant_oh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_intr    <= 1'b0;
      r_vector  <= '0;
      r_vec_id  <= '0;
      r_irq_q   <= '0;
      r_pending <= '0;
      r_isr     <= '0;
      r_mask    <= NUM_SRC'(RST_MASK);
      r_mode    <= '0;
      r_base    <= '0;
    end else begin
      r_irq_q   <= irq;
      r_pending <= w_pending_next;
      r_isr     <= w_isr_next;

      if (cfg_we) begin
        case (cfg_addr)
          ADDR_MASK: r_mask <= NUM_SRC'(cfg_wdata);
          ADDR_MODE: r_mode <= NUM_SRC'(cfg_wdata);
          ADDR_BASE: r_base <= VEC_W'(cfg_wdata);
          default:   ;
        endcase
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cand_ok) begin
            r_state  <= ST_REQ;
            r_intr   <= 1'b1;
            r_vec_id <= w_cand_id;
            r_vector <= w_cand_vec;
          end
        end
        ST_REQ: begin
          // An acknowledge is honoured even if the candidate vanishes that cycle.
          if (inta) begin
            r_state <= ST_IDLE;
            r_intr  <= 1'b0;
          end else if (!w_cand_ok) begin
            r_state <= ST_IDLE;
            r_intr  <= 1'b0;
          end else begin
            r_vec_id <= w_cand_id;
            r_vector <= w_cand_vec;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_intr  <= 1'b0;
        end
      endcase
    end
  end

  assign intr      = r_intr;
  assign vector    = r_vector;
  assign pending_o = r_pending;
  assign isr_o     = r_isr;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with hand-computed expected values.
module tb_intr_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] irq;
  logic       intr;
  logic       inta;
  logic [7:0] vector;
  logic       eoi;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] pending_o;
  logic [7:0] isr_o;

  int n_checks = 0;
  int n_fail   = 0;

  intr_ctrl #(.NUM_SRC(8), .VEC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .intr      (intr),
    .inta      (inta),
    .vector    (vector),
    .eoi       (eoi),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .pending_o (pending_o),
    .isr_o     (isr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic pulse_inta();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  task automatic pulse_irq(input logic [7:0] bits);
    irq = bits;
    tick();
    irq = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irq = 8'hFF; inta = 1'b0; eoi = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;

    // Reset with all lines high
    tick(); tick();
    check_eq("rst_intr",    32'(intr),      32'h0);
    check_eq("rst_vector",  32'(vector),    32'h00);
    check_eq("rst_pending", 32'(pending_o), 32'h00);
    check_eq("rst_isr",     32'(isr_o),     32'h00);
    rst = 1'b0;
    tick();
    check_eq("lvl_after_rst_pending", 32'(pending_o), 32'hFF);
    tick(); tick();
    check_eq("masked_no_intr", 32'(intr), 32'h0);
    irq = 8'h00;
    tick();
    check_eq("lvl_drop_pending", 32'(pending_o), 32'h00);

    // Single edge request on source 3
    cfg_write(2'd0, 8'hF7);
    cfg_write(2'd1, 8'h08);
    cfg_write(2'd2, 8'h40);
    irq = 8'h08;
    tick();
    check_eq("edge_pend_n1", 32'(pending_o), 32'h08);
    check_eq("edge_intr_n1", 32'(intr),      32'h0);
    tick();
    check_eq("edge_intr_n2", 32'(intr),   32'h1);
    check_eq("edge_vec_n2",  32'(vector), 32'h43);
    pulse_inta();
    check_eq("grant3_intr",    32'(intr),      32'h0);
    check_eq("grant3_isr",     32'(isr_o),     32'h08);
    check_eq("grant3_pending", 32'(pending_o), 32'h00);
    irq = 8'h00;

    // Nesting: source 1 preempts in-service 3, source 5 is blocked
    cfg_write(2'd0, 8'h00);
    cfg_write(2'd1, 8'hFF);
    pulse_irq(8'h02);
    tick();
    check_eq("nest1_intr", 32'(intr),   32'h1);
    check_eq("nest1_vec",  32'(vector), 32'h41);
    pulse_inta();
    check_eq("nest1_isr", 32'(isr_o), 32'h0A);
    pulse_irq(8'h20);
    tick(); tick();
    check_eq("nest5_blocked", 32'(intr),      32'h0);
    check_eq("nest5_pending", 32'(pending_o), 32'h20);
    pulse_eoi();
    check_eq("eoi1_isr", 32'(isr_o), 32'h08);
    tick();
    check_eq("eoi1_still_blocked", 32'(intr), 32'h0);
    pulse_eoi();
    check_eq("eoi2_isr", 32'(isr_o), 32'h00);
    tick();
    check_eq("nest5_intr", 32'(intr),   32'h1);
    check_eq("nest5_vec",  32'(vector), 32'h45);
    pulse_inta();
    check_eq("grant5_isr", 32'(isr_o), 32'h20);
    pulse_eoi();
    check_eq("eoi5_isr", 32'(isr_o), 32'h00);

    // Simultaneous 2 and 6
    pulse_irq(8'h44);
    tick();
    check_eq("sim_vec", 32'(vector), 32'h42);
    pulse_inta();
    check_eq("sim_isr",     32'(isr_o),     32'h04);
    check_eq("sim_pending", 32'(pending_o), 32'h40);
    tick(); tick();
    check_eq("sim6_blocked", 32'(intr), 32'h0);
    pulse_eoi();
    tick();
    check_eq("req6_vec", 32'(vector), 32'h46);
    // Source 0 preempts while source 6 is requesting
    pulse_irq(8'h01);
    check_eq("preempt_vec_old", 32'(vector), 32'h46);
    tick();
    check_eq("preempt_intr", 32'(intr),   32'h1);
    check_eq("preempt_vec",  32'(vector), 32'h40);
    pulse_inta();
    check_eq("grant0_isr", 32'(isr_o), 32'h01);
    pulse_eoi();
    tick();
    check_eq("re6_vec", 32'(vector), 32'h46);
    pulse_inta();
    pulse_eoi();
    check_eq("sim_clean_isr", 32'(isr_o), 32'h00);

    // Withdraw by masking source 4 while it is requesting
    pulse_irq(8'h10);
    tick();
    check_eq("wd_intr_up", 32'(intr),   32'h1);
    check_eq("wd_vec",     32'(vector), 32'h44);
    cfg_write(2'd0, 8'h10);
    tick();
    check_eq("wd_intr_down", 32'(intr), 32'h0);
    pulse_inta();
    check_eq("wd_inta_ignored_isr",  32'(isr_o), 32'h00);
    check_eq("wd_inta_ignored_intr", 32'(intr),  32'h0);
    cfg_write(2'd3, 8'h10);
    check_eq("w1c_pending", 32'(pending_o), 32'h00);
    cfg_write(2'd0, 8'h00);

    // Level mode on source 7 with vector wrap
    cfg_write(2'd1, 8'h00);
    cfg_write(2'd2, 8'hF9);
    irq = 8'h80;
    tick(); tick();
    check_eq("lvl_intr", 32'(intr),   32'h1);
    check_eq("lvl_wrap", 32'(vector), 32'h00);
    pulse_inta();
    check_eq("lvl_isr",         32'(isr_o),     32'h80);
    check_eq("lvl_pend_grant",  32'(pending_o), 32'h80);
    tick();
    check_eq("lvl_no_reassert", 32'(intr), 32'h0);
    pulse_eoi();
    check_eq("lvl_eoi_isr",  32'(isr_o),     32'h00);
    check_eq("lvl_eoi_pend", 32'(pending_o), 32'h80);
    tick();
    check_eq("lvl_reassert",  32'(intr),      32'h1);
    check_eq("lvl_pend_hold", 32'(pending_o), 32'h80);

    // Reset while in REQ
    rst = 1'b1;
    tick();
    check_eq("rst_req_intr", 32'(intr),      32'h0);
    check_eq("rst_req_pend", 32'(pending_o), 32'h00);
    check_eq("rst_req_vec",  32'(vector),    32'h00);
    rst = 1'b0;
    irq = 8'h00;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
